alu_sequencer: RTL

Instruction-level controller that sequences the 8-bit combinational ALU (AND/OR/NAND/NOR/ADD/SUB) for the CPU. It accepts one instruction at a time over a valid/ready handshake and reads two operands from a 4-entry, 8-bit register file that it owns. It drives the ALU, waits a programmable settle time, captures the result, writes it back and reports completion. It sits between the instruction source (fetch/decode or test host) and the ALU instance.

---
 rtl/alu_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit combinational ALU: owns a 4x8 register file,
// accepts one instruction at a time, drives the ALU, waits ALU_WAIT cycles, writes back.
module alu_sequencer #(
  parameter int ALU_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  output logic        done,
  output logic [7:0]  result,
  output logic        zero,
  output logic        error,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  // Handshake: an instruction is taken on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, so a held instr_valid never causes a second accept while busy.

  typedef enum logic [1:0] {IDLE, EXEC, WB} stateT;

  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  stateT       state;
  logic [7:0]  regFile [4];
  logic [2:0]  opQ;
  logic [1:0]  dstQ;
  logic [3:0]  waitCnt;

  logic [2:0]  newOp;
  logic [1:0]  newDst;
  logic [1:0]  newSrcA;
  logic [1:0]  newSrcB;
  logic [7:0]  newImm;

  assign newOp   = instr[15:13];
  assign newDst  = instr[12:11];
  assign newSrcA = instr[10:9];
  assign newSrcB = instr[8:7];
  assign newImm  = instr[7:0];

  assign dbg_data = regFile[dbg_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      for (int i = 0; i < 4; i++) regFile[i] <= 8'h00;
      opQ         <= 3'b000;
      dstQ        <= 2'b00;
      waitCnt     <= 4'd0;
      instr_ready <= 1'b1;
      alu_opcode  <= 3'b000;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      done        <= 1'b0;
      result      <= 8'h00;
      zero        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      zero  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            opQ         <= newOp;
            dstQ        <= newDst;
            instr_ready <= 1'b0;
            if (newOp == OP_LDI || newOp == OP_ILL) begin
              // No ALU involvement: straight to write-back with the outcome registered now.
              state  <= WB;
              done   <= 1'b1;
              result <= (newOp == OP_LDI) ? newImm : 8'h00;
              zero   <= (newOp == OP_LDI) && (newImm == 8'h00);
              error  <= (newOp == OP_ILL);
            end else begin
              state      <= EXEC;
              waitCnt    <= 4'(ALU_WAIT);
              alu_opcode <= newOp;
              alu_a      <= regFile[newSrcA];
              alu_b      <= regFile[newSrcB];
            end
          end
        end
        EXEC: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) begin
            state      <= WB;
            done       <= 1'b1;
            result     <= alu_result;
            zero       <= (alu_result == 8'h00);
            alu_opcode <= 3'b000;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
          end
        end
        WB: begin
          if (opQ != OP_ILL) regFile[dstQ] <= result;
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
